// File: rtl/sub1_serial.sv
// sub1_serial: bit-serial 8-bit subtractor (r1 - r2), LSB first, one bit per clock.
// Produces an unsigned borrow-out and, optionally, a signed overflow flag.
// Optional feature macro: SUB1_SERIAL_SIGNED_OVF_EN.
//   Defined   - ovf is registered at completion from the retained operand MSBs.
//   Undefined - ovf is tied to 0 and the operand-MSB registers are not built.
module sub1_serial (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] r1,
    input  logic [7:0] r2,
    output logic [7:0] diff,
    output logic       borrow,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   res;
    logic           br;
    logic [CW-1:0]  cnt;

    logic           load_c;
    logic           step_c;
    logic           last_c;
    logic           d_c;
    logic           br_n_c;

    // One full-subtractor bit slice on the current LSBs.
    assign d_c    = a[0] ^ b[0] ^ br;
    assign br_n_c = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_n = state;
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (cnt == CW'(W - 1)) begin
                    last_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand shift registers, result accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= '0;
            b      <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_c) begin
                a    <= r1;
                b    <= r2;
                br   <= 1'b0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (step_c) begin
                a   <= {1'b0, a[W-1:1]};
                b   <= {1'b0, b[W-1:1]};
                res <= {d_c, res[W-1:1]};
                br  <= br_n_c;
                cnt <= cnt + CW'(1);
                if (last_c) begin
                    diff   <= {d_c, res[W-1:1]};
                    borrow <= br_n_c;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
            end
        end
    end

`ifdef SUB1_SERIAL_SIGNED_OVF_EN
    logic a_msb;
    logic b_msb;

    // Signed overflow: operand signs differ and the result sign differs from the minuend.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load_c) begin
                a_msb <= r1[W-1];
                b_msb <= r2[W-1];
            end
            if (last_c) begin
                ovf <= (a_msb != b_msb) && (d_c != a_msb);
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sub1_serial.sv
// Self-checking bench for sub1_serial: directed cases, start-while-busy,
// reset abort, back-to-back and randomized operands against an arithmetic model.
module tb_sub1_serial;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fails;

    sub1_serial dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .r1     (r1),
        .r2     (r2),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer subtraction and signed range test.
    function automatic logic [7:0] m_diff(input logic [7:0] x, input logic [7:0] y);
        int d;
        d = int'(x) - int'(y) + 256;
        return 8'(d % 256);
    endfunction

    function automatic logic m_borrow(input logic [7:0] x, input logic [7:0] y);
        return (int'(x) - int'(y)) < 0;
    endfunction

    function automatic logic m_ovf(input logic [7:0] x, input logic [7:0] y);
`ifdef SUB1_SERIAL_SIGNED_OVF_EN
        int sx;
        int sy;
        sx = int'(signed'(x));
        sy = int'(signed'(y));
        return ((sx - sy) > 127) || ((sx - sy) < -128);
`else
        return 1'b0;
`endif
    endfunction

    // Runs one operation and reports what was observed (no checking here).
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         output int lat, output logic [7:0] od, output logic obr,
                         output logic oov, output logic busy_ok,
                         output logic busy_at_done, output logic done_after);
        @(negedge clk);
        start = 1'b1;
        r1    = x;
        r2    = y;
        @(negedge clk);
        start   = 1'b0;
        r1      = 8'($urandom);
        r2      = 8'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        od           = diff;
        obr          = borrow;
        oov          = ovf;
        busy_at_done = busy;
        @(negedge clk);
        done_after   = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        r1    = 8'h55;
        r2    = 8'h22;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({diff, borrow, ovf, busy, done} !== 12'h000) begin
            n_fails++;
            $display("FAIL reset_values: got diff=%h borrow=%b ovf=%b busy=%b done=%b want all 0",
                     diff, borrow, ovf, busy, done);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [7:0] xs [3];
        logic [7:0] ys [3];
        int lat;
        logic [7:0] od;
        logic obr, oov, bok, bad, dnx;
        xs = '{8'h05, 8'h03, 8'h80};
        ys = '{8'h03, 8'h05, 8'h01};
        for (int i = 0; i < 3; i++) begin
            do_op(xs[i], ys[i], lat, od, obr, oov, bok, bad, dnx);
            n_checks++;
            if (lat !== 8) begin
                n_fails++;
                $display("FAIL dir_latency[%0d]: got %0d want 8", i, lat);
            end
            n_checks++;
            if (od !== m_diff(xs[i], ys[i]) || obr !== m_borrow(xs[i], ys[i])
                || oov !== m_ovf(xs[i], ys[i])) begin
                n_fails++;
                $display("FAIL dir_result[%0d] %h-%h: got diff=%h borrow=%b ovf=%b want %h %b %b",
                         i, xs[i], ys[i], od, obr, oov, m_diff(xs[i], ys[i]),
                         m_borrow(xs[i], ys[i]), m_ovf(xs[i], ys[i]));
            end
            n_checks++;
            if (!bok || bad !== 1'b0 || dnx !== 1'b0) begin
                n_fails++;
                $display("FAIL dir_handshake[%0d]: got busy_run=%b busy_done=%b done_next=%b want 1 0 0",
                         i, bok, bad, dnx);
            end
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        @(negedge clk);
        start = 1'b1;
        r1    = 8'h10;
        r2    = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        r1    = 8'hFF;
        r2    = 8'h00;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                pulses++;
                n_checks++;
                if (diff !== 8'h0F || borrow !== 1'b0) begin
                    n_fails++;
                    $display("FAIL ignore_start_result: got diff=%h borrow=%b want 0f 0", diff, borrow);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fails++;
            $display("FAIL ignore_start_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        logic [7:0] od;
        logic obr, oov, bok, bad, dnx;
        @(negedge clk);
        start = 1'b1;
        r1    = 8'h20;
        r2    = 8'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0 || ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_outputs: got busy=%b done=%b diff=%h borrow=%b ovf=%b want 0 0 00 0 0",
                     busy, done, diff, borrow, ovf);
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fails++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", pulses);
        end
        do_op(8'h00, 8'h00, lat, od, obr, oov, bok, bad, dnx);
        n_checks++;
        if (lat !== 8 || od !== 8'h00 || obr !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_recover: got lat=%0d diff=%h borrow=%b want 8 00 0", lat, od, obr);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1;
        r1    = 8'h09;
        r2    = 8'h04;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 8 || diff !== 8'h05 || borrow !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_first: got lat=%0d diff=%h borrow=%b want 8 05 0", lat, diff, borrow);
        end
        start = 1'b1;
        r1    = 8'h00;
        r2    = 8'h01;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 8 || diff !== 8'hFF || borrow !== 1'b1 || ovf !== m_ovf(8'h00, 8'h01)) begin
            n_fails++;
            $display("FAIL b2b_second: got lat=%0d diff=%h borrow=%b ovf=%b want 8 ff 1 %b",
                     lat, diff, borrow, ovf, m_ovf(8'h00, 8'h01));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] x, y, od;
        logic obr, oov, bok, bad, dnx;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if (i == 0) begin x = 8'h7F; y = 8'hFF; end
            if (i == 1) begin x = 8'hFF; y = 8'hFF; end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(x, y, lat, od, obr, oov, bok, bad, dnx);
            n_checks++;
            if (lat !== 8 || od !== m_diff(x, y) || obr !== m_borrow(x, y) || oov !== m_ovf(x, y)
                || !bok || bad !== 1'b0 || dnx !== 1'b0) begin
                n_fails++;
                $display("FAIL rand[%0d] %h-%h: got lat=%0d diff=%h borrow=%b ovf=%b hs=%b%b%b want 8 %h %b %b 100",
                         i, x, y, lat, od, obr, oov, bok, bad, dnx,
                         m_diff(x, y), m_borrow(x, y), m_ovf(x, y));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        start    = 1'b0;
        r1       = 8'h00;
        r2       = 8'h00;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
